alu_issue_ctrl: RTL



---
 rtl/mips_alu_pkg.sv | 20 ++
 rtl/alu_issue_decode.sv | 54 +++++
 rtl/alu_issue_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU encodings: funct/opcode constants and the issue FSM state type.
package mips_alu_pkg;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOP = 6'b000000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of the supported MIPS subset into ALU funct, operands and destination.
module alu_issue_decode
  import mips_alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [5:0]  funct,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  rd,
  output logic        legal
);

  logic [5:0] opcode;
  logic [5:0] rfunct;
  logic       unused_rs_field;

  assign opcode = instr[31:26];
  assign rfunct = instr[5:0];
  // Register numbers come in pre-read as rs_data/rt_data, so the rs field itself is not needed.
  assign unused_rs_field = ^instr[25:21];

  always_comb begin
    funct = FN_NOP;
    a     = '0;
    b     = '0;
    rd    = '0;
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (rfunct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            funct = rfunct;
            a     = rs_data;
            b     = rt_data;
            rd    = instr[15:11];
            legal = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        funct = FN_ADD;
        a     = rs_data;
        b     = {{16{instr[15]}}, instr[15:0]};
        rd    = instr[20:16];
        legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to the two-phase ALU, holds operands across its phases,
// then returns a MIPS writeback record (signed slt, overflow suppression, $0 block).
module alu_issue_ctrl
  import mips_alu_pkg::*;
#(
  parameter int ALU_LAT = 3,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [5:0]  alu_funct,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_we,
  output logic        res_ovf,
  output logic        res_illegal
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;

  logic [5:0]  dec_funct;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic        dec_legal;

  logic        sum_msb;
  logic [30:0] sum_low_unused;
  logic        diff_msb;
  logic [30:0] diff_low_unused;
  logic        ovf_calc;
  logic        slt_bit;

  alu_issue_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .funct   (dec_funct),
    .a       (dec_a),
    .b       (dec_b),
    .rd      (dec_rd),
    .legal   (dec_legal)
  );

  // Overflow and signed compare are derived from the held operands; the ALU's own
  // overflow flag lags an evaluation and its compare is unsigned, so neither is trusted.
  assign {sum_msb, sum_low_unused}   = alu_a + alu_b;
  assign {diff_msb, diff_low_unused} = alu_a - alu_b;
  assign slt_bit = $signed(alu_a) < $signed(alu_b);

  always_comb begin
    ovf_calc = 1'b0;
    case (alu_funct)
      FN_ADD:  ovf_calc = (alu_a[31] == alu_b[31]) && (sum_msb != alu_a[31]);
      FN_SUB:  ovf_calc = (alu_a[31] != alu_b[31]) && (diff_msb != alu_a[31]);
      default: ovf_calc = 1'b0;
    endcase
  end

  assign instr_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      alu_funct   <= FN_NOP;
      alu_a       <= '0;
      alu_b       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
      res_we      <= 1'b0;
      res_ovf     <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (dec_legal) begin
              state     <= ST_HOLD;
              cnt       <= '0;
              alu_funct <= dec_funct;
              alu_a     <= dec_a;
              alu_b     <= dec_b;
              rd_q      <= dec_rd;
            end else begin
              state       <= ST_RESP;
              res_valid   <= 1'b1;
              res_illegal <= 1'b1;
              res_we      <= 1'b0;
              res_data    <= '0;
              res_rd      <= '0;
              res_ovf     <= 1'b0;
            end
          end
        end
        // Operands stay frozen until the ALU has seen a full latch/compute cycle.
        ST_HOLD: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state       <= ST_RESP;
            res_valid   <= 1'b1;
            res_illegal <= 1'b0;
            res_data    <= (alu_funct == FN_SLT) ? {31'b0, slt_bit} : alu_out;
            res_rd      <= rd_q;
            res_ovf     <= ovf_calc;
            res_we      <= !ovf_calc && (rd_q != 5'd0);
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rd_q        <= '0;
            alu_funct   <= FN_NOP;
            alu_a       <= '0;
            alu_b       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_rd      <= '0;
            res_we      <= 1'b0;
            res_ovf     <= 1'b0;
            res_illegal <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
